// File: rtl/parking_pkg.sv
// Shared types and default timing for the parking-bay sensor front-end.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE
  } state_e;

  localparam int unsigned TRIG_CYCLES_DEF    = 500;
  localparam int unsigned PERIOD_CYCLES_DEF  = 3000000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1500000;
  localparam int unsigned CNT_W_DEF          = 22;
  localparam int unsigned NEAR_CYCLES_DEF    = 29000;
  localparam int unsigned FAR_CYCLES_DEF     = 35000;
  localparam int unsigned CONFIRM_DEF        = 3;

endpackage

// File: rtl/echo_sync.sv
// 2-FF synchronizer for an asynchronous level input, with rise/fall pulses
// derived from the synchronized level.
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-stage synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_presence_detector.sv
// Ultrasonic parking-bay presence detector: trigger/echo measurement FSM,
// near/far classification and debounced arrive/depart events.
// Optional macro PRESENCE_HYSTERESIS_EN: readings between NEAR_CYCLES and
// FAR_CYCLES become neutral instead of counting as far.
module ultrasonic_presence_detector
  import parking_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned NEAR_CYCLES    = NEAR_CYCLES_DEF,
  parameter int unsigned FAR_CYCLES     = FAR_CYCLES_DEF,
  parameter int unsigned CONFIRM        = CONFIRM_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic [CNT_W-1:0] echo_cycles,
  output logic             meas_valid,
  output logic             meas_timeout,
  output logic             occupied,
  output logic             car_arrive,
  output logic             car_depart
);

`ifdef PRESENCE_HYSTERESIS_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  localparam int unsigned PER_W = $clog2(PERIOD_CYCLES + 1);
  localparam logic [PER_W-1:0] PERIOD_M1  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIG_M1    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] NEAR_C     = CNT_W'(NEAR_CYCLES);
  // Without hysteresis the far threshold collapses onto the near one, so
  // "far" is exactly "valid and not near".
  localparam logic [CNT_W-1:0] FAR_C      = CNT_W'(HYST_EN ? FAR_CYCLES : NEAR_CYCLES);
  localparam logic [3:0]       CONFIRM_C  = 4'(CONFIRM);

  state_e           state_q;
  logic [PER_W-1:0] period_q;
  logic [CNT_W-1:0] cnt_q;
  logic             echo_lvl;
  logic             echo_rise;
  logic             echo_fall;

  logic [3:0]       near_cnt_q, near_cnt_d;
  logic [3:0]       far_cnt_q, far_cnt_d;
  logic             is_near;
  logic             is_far;

  echo_sync u_echo_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(echo),
    .sync_o (echo_lvl),
    .rise_o (echo_rise),
    .fall_o (echo_fall)
  );

  // Measurement sequencer: period pacing, trigger pulse, echo timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      period_q     <= PERIOD_M1;
      cnt_q        <= '0;
      trig         <= 1'b0;
      echo_cycles  <= '0;
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
    end else begin
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
      // Period counter runs through every state so rises stay PERIOD apart.
      if (period_q != PERIOD_M1) period_q <= period_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (enable && (period_q == PERIOD_M1)) begin
            state_q  <= TRIG;
            period_q <= '0;
            cnt_q    <= '0;
            trig     <= 1'b1;
          end
        end
        TRIG: begin
          if (cnt_q == TRIG_M1) begin
            state_q <= WAIT_RISE;
            trig    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            state_q <= MEASURE;
            cnt_q   <= CNT_W'(1);
          end else if (cnt_q == TIMEOUT_M1) begin
            state_q      <= IDLE;
            meas_timeout <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            state_q     <= IDLE;
            echo_cycles <= cnt_q;
            meas_valid  <= 1'b1;
          end else if (cnt_q == TIMEOUT_C) begin
            state_q      <= IDLE;
            meas_timeout <= 1'b1;
          end else if (echo_lvl) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign is_near = meas_valid && (echo_cycles < NEAR_C);
  assign is_far  = meas_timeout || (meas_valid && (echo_cycles >= FAR_C));

  // Saturating confirm streaks; an opposite reading clears the other streak.
  always_comb begin
    near_cnt_d = near_cnt_q;
    far_cnt_d  = far_cnt_q;
    if (is_near) begin
      near_cnt_d = (near_cnt_q == CONFIRM_C) ? near_cnt_q : near_cnt_q + 4'd1;
      far_cnt_d  = '0;
    end else if (is_far) begin
      far_cnt_d  = (far_cnt_q == CONFIRM_C) ? far_cnt_q : far_cnt_q + 4'd1;
      near_cnt_d = '0;
    end
  end

  // Debounced occupancy level and one-cycle transition events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      near_cnt_q <= '0;
      far_cnt_q  <= '0;
      occupied   <= 1'b0;
      car_arrive <= 1'b0;
      car_depart <= 1'b0;
    end else begin
      near_cnt_q <= near_cnt_d;
      far_cnt_q  <= far_cnt_d;
      car_arrive <= 1'b0;
      car_depart <= 1'b0;
      if (is_near && !occupied && (near_cnt_d == CONFIRM_C)) begin
        occupied   <= 1'b1;
        car_arrive <= 1'b1;
      end else if (is_far && occupied && (far_cnt_d == CONFIRM_C)) begin
        occupied   <= 1'b0;
        car_depart <= 1'b1;
      end
    end
  end

endmodule
